surfturf_cmd_scheduler: RTL and testbench

- Shares the single per-frame outbound SURF command slot between three sysclk-domain requesters: run commands, triggers and firmware-update bytes.
- Sits downstream of the SURFTURF register core's runcmd_/trig_/fw_ AXI4-Stream outputs and upstream of the rackbus command serializer.
- Arbitrates once per frame on sync_i with fixed priority plus starvation guarantees.
- Carries firmware mark bits alongside the byte they tag, and reports completion.

---
 rtl/surfturf_cmd_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_surfturf_cmd_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/surfturf_cmd_scheduler.sv
// rtl/surfturf_cmd_scheduler.sv - per-frame SURF command slot arbiter (runcmd / trig / fw)
//
// Picks one of three AXI4-Stream-style requesters once per frame (sync_i) and
// issues a registered 20-bit command slot the cycle after. Trigger has fixed
// priority; run commands and firmware bytes are forced through after
// STARVE_LIMIT consecutive lost frames (runcmd ahead of fw).
//
// Ports:
//   sysclk_i, sysclk_rst_n_i        clock, synchronous active-low reset
//   sync_i                          frame strobe (one-cycle pulse)
//   runcmd_t*/trig_t*/fw_t*         input streams; treadys pulse only for the winner
//   fw_mark_i                       mark levels carried with an issued fw byte
//   fw_marked_o                     pulse with cmd_tvalid_o when a marked fw byte goes out
//   cmd_tdata_o / cmd_tvalid_o      {type[1:0], mark[1:0], payload[15:0]} and slot pulse
//
// Optional: define SURFTURF_CMD_SCHED_STATS_EN to add wrapping per-type slot
// counters (stat_*_o) and a forced-win counter.

module surfturf_cmd_scheduler #(
    parameter int STARVE_LIMIT = 4,
    parameter int TRIG_BITS    = 15,
    parameter int RUNCMD_BITS  = 2
) (
    input  logic                   sysclk_i,
    input  logic                   sysclk_rst_n_i,
    input  logic                   sync_i,
    input  logic [RUNCMD_BITS-1:0] runcmd_tdata,
    input  logic                   runcmd_tvalid,
    output logic                   runcmd_tready,
    input  logic [TRIG_BITS-1:0]   trig_tdata,
    input  logic                   trig_tvalid,
    output logic                   trig_tready,
    input  logic [7:0]             fw_tdata,
    input  logic                   fw_tvalid,
    output logic                   fw_tready,
    input  logic [1:0]             fw_mark_i,
    output logic                   fw_marked_o,
    output logic [19:0]            cmd_tdata_o,
    output logic                   cmd_tvalid_o
`ifdef SURFTURF_CMD_SCHED_STATS_EN
    ,
    output logic [15:0]            stat_trig_o,
    output logic [15:0]            stat_runcmd_o,
    output logic [15:0]            stat_fw_o,
    output logic [15:0]            stat_idle_o,
    output logic [7:0]             stat_forced_o
`endif
);

    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    // Encodings double as the slot type field.
    typedef enum logic [1:0] {
        SEL_IDLE = 2'b00,
        SEL_RUN  = 2'b01,
        SEL_TRIG = 2'b10,
        SEL_FW   = 2'b11
    } sel_t;

    sel_t        w_sel;
    logic        w_forced;
    logic        w_go;
    logic [15:0] w_payload;
    logic [1:0]  w_mark;

    logic [3:0]  r_runcmd_starve;
    logic [3:0]  r_fw_starve;
    logic [19:0] r_cmd_tdata;
    logic        r_cmd_tvalid;
    logic        r_fw_marked;

    always_comb begin
        w_sel    = SEL_IDLE;
        w_forced = 1'b0;
        if (runcmd_tvalid && (r_runcmd_starve >= LP_LIMIT)) begin
            w_sel    = SEL_RUN;
            w_forced = 1'b1;
        end else if (fw_tvalid && (r_fw_starve >= LP_LIMIT)) begin
            w_sel    = SEL_FW;
            w_forced = 1'b1;
        end else if (trig_tvalid) begin
            w_sel = SEL_TRIG;
        end else if (runcmd_tvalid) begin
            w_sel = SEL_RUN;
        end else if (fw_tvalid) begin
            w_sel = SEL_FW;
        end
    end

    always_comb begin
        w_payload = 16'h0000;
        w_mark    = 2'b00;
        case (w_sel)
            SEL_RUN:  w_payload = 16'(runcmd_tdata);
            SEL_TRIG: w_payload = 16'(trig_tdata);
            SEL_FW: begin
                w_payload = 16'(fw_tdata);
                w_mark    = fw_mark_i;
            end
            default:  w_payload = 16'h0000;
        endcase
    end

    // A frame that coincides with reset is dropped, so no beat may be accepted.
    assign w_go          = sync_i && sysclk_rst_n_i;
    assign runcmd_tready = w_go && (w_sel == SEL_RUN);
    assign trig_tready   = w_go && (w_sel == SEL_TRIG);
    assign fw_tready     = w_go && (w_sel == SEL_FW);

    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rst_n_i) begin
            r_runcmd_starve <= 4'd0;
            r_fw_starve     <= 4'd0;
            r_cmd_tdata     <= 20'd0;
            r_cmd_tvalid    <= 1'b0;
            r_fw_marked     <= 1'b0;
        end else begin
            r_cmd_tvalid <= sync_i;
            r_fw_marked  <= sync_i && (w_sel == SEL_FW) && (fw_mark_i != 2'b00);
            if (sync_i) begin
                r_cmd_tdata <= {w_sel, w_mark, w_payload};
                if (!runcmd_tvalid || (w_sel == SEL_RUN))
                    r_runcmd_starve <= 4'd0;
                else if (r_runcmd_starve != 4'hF)
                    r_runcmd_starve <= r_runcmd_starve + 4'd1;
                if (!fw_tvalid || (w_sel == SEL_FW))
                    r_fw_starve <= 4'd0;
                else if (r_fw_starve != 4'hF)
                    r_fw_starve <= r_fw_starve + 4'd1;
            end
        end
    end

    assign cmd_tdata_o  = r_cmd_tdata;
    assign cmd_tvalid_o = r_cmd_tvalid;
    assign fw_marked_o  = r_fw_marked;

`ifdef SURFTURF_CMD_SCHED_STATS_EN
    logic        r_forced;
    logic [15:0] r_stat_trig;
    logic [15:0] r_stat_runcmd;
    logic [15:0] r_stat_fw;
    logic [15:0] r_stat_idle;
    logic [7:0]  r_stat_forced;

    // Counts are taken on the slot pulse, using the type just loaded.
    always_ff @(posedge sysclk_i) begin
        if (!sysclk_rst_n_i) begin
            r_forced      <= 1'b0;
            r_stat_trig   <= 16'd0;
            r_stat_runcmd <= 16'd0;
            r_stat_fw     <= 16'd0;
            r_stat_idle   <= 16'd0;
            r_stat_forced <= 8'd0;
        end else begin
            if (sync_i)
                r_forced <= w_forced;
            if (r_cmd_tvalid) begin
                case (r_cmd_tdata[19:18])
                    2'b01:   r_stat_runcmd <= r_stat_runcmd + 16'd1;
                    2'b10:   r_stat_trig   <= r_stat_trig + 16'd1;
                    2'b11:   r_stat_fw     <= r_stat_fw + 16'd1;
                    default: r_stat_idle   <= r_stat_idle + 16'd1;
                endcase
                if (r_forced)
                    r_stat_forced <= r_stat_forced + 8'd1;
            end
        end
    end

    assign stat_trig_o   = r_stat_trig;
    assign stat_runcmd_o = r_stat_runcmd;
    assign stat_fw_o     = r_stat_fw;
    assign stat_idle_o   = r_stat_idle;
    assign stat_forced_o = r_stat_forced;
`else
    logic w_unused_forced;
    assign w_unused_forced = w_forced;
`endif

endmodule

// File: tb/tb_surfturf_cmd_scheduler.sv
// tb/tb_surfturf_cmd_scheduler.sv - scoreboard bench for surfturf_cmd_scheduler

module tb_surfturf_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic [1:0]  runcmd_tdata = '0;
    logic        runcmd_tvalid = 1'b0;
    logic        runcmd_tready;
    logic [14:0] trig_tdata = '0;
    logic        trig_tvalid = 1'b0;
    logic        trig_tready;
    logic [7:0]  fw_tdata = '0;
    logic        fw_tvalid = 1'b0;
    logic        fw_tready;
    logic [1:0]  fw_mark = '0;
    logic        fw_marked;
    logic [19:0] cmd_tdata;
    logic        cmd_tvalid;

    logic        chk_reset = 1'b0;
    logic        done = 1'b0;

    typedef struct packed {
        logic [19:0] tdata;
        logic        marked;
    } cmd_exp_t;

    logic [2:0] q_rdy [$];
    cmd_exp_t   q_cmd [$];

    surfturf_cmd_scheduler #(
        .STARVE_LIMIT(4),
        .TRIG_BITS(15),
        .RUNCMD_BITS(2)
    ) dut (
        .sysclk_i(clk),
        .sysclk_rst_n_i(rst_n),
        .sync_i(sync),
        .runcmd_tdata(runcmd_tdata),
        .runcmd_tvalid(runcmd_tvalid),
        .runcmd_tready(runcmd_tready),
        .trig_tdata(trig_tdata),
        .trig_tvalid(trig_tvalid),
        .trig_tready(trig_tready),
        .fw_tdata(fw_tdata),
        .fw_tvalid(fw_tvalid),
        .fw_tready(fw_tready),
        .fw_mark_i(fw_mark),
        .fw_marked_o(fw_marked),
        .cmd_tdata_o(cmd_tdata),
        .cmd_tvalid_o(cmd_tvalid)
    );

    always #5 clk = ~clk;

    // Monitor: all comparisons and counts live here.
    int   n_vec = 0;
    int   n_err = 0;
    int   cycles = 0;
    logic prev_sync = 1'b0;

    always @(negedge clk) begin
        logic [2:0] rdy;
        cmd_exp_t   e;
        rdy = {fw_tready, trig_tready, runcmd_tready};
        cycles++;

        if (chk_reset) begin
            n_vec++;
            if (cmd_tdata !== 20'd0 || cmd_tvalid !== 1'b0 || fw_marked !== 1'b0 || rdy !== 3'b000) begin
                n_err++;
                $display("FAIL reset_state: tdata=%05h tvalid=%b marked=%b rdy=%b, required 00000/0/0/000",
                         cmd_tdata, cmd_tvalid, fw_marked, rdy);
            end
        end

        if (sync) begin
            n_vec++;
            if (q_rdy.size() == 0) begin
                n_err++;
                $display("FAIL tready_unexpected_sync: rdy=%b with no expectation", rdy);
            end else begin
                logic [2:0] er;
                er = q_rdy.pop_front();
                if (rdy !== er) begin
                    n_err++;
                    $display("FAIL tready: rdy{fw,trig,run}=%b, required %b", rdy, er);
                end
            end
        end else if (rdy !== 3'b000) begin
            n_err++;
            $display("FAIL tready_outside_sync: rdy=%b, required 000", rdy);
        end

        if (cmd_tvalid) begin
            n_vec++;
            if (!prev_sync) begin
                n_err++;
                $display("FAIL latency: cmd_tvalid_o=1 without sync_i in previous cycle");
            end
            if (q_cmd.size() == 0) begin
                n_err++;
                $display("FAIL cmd_unexpected: tdata=%05h, required no slot", cmd_tdata);
            end else begin
                e = q_cmd.pop_front();
                if (cmd_tdata !== e.tdata || fw_marked !== e.marked) begin
                    n_err++;
                    $display("FAIL cmd_slot: tdata=%05h marked=%b, required %05h marked=%b",
                             cmd_tdata, fw_marked, e.tdata, e.marked);
                end
            end
        end else if (fw_marked) begin
            n_err++;
            $display("FAIL marked_without_slot: fw_marked_o=1 while cmd_tvalid_o=0");
        end

        prev_sync = sync && rst_n;

        if (done) begin
            n_vec++;
            if (q_rdy.size() != 0 || q_cmd.size() != 0) begin
                n_err++;
                $display("FAIL drain: %0d tready and %0d slot expectations left, required 0",
                         q_rdy.size(), q_cmd.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
        end

        if (cycles > 5000) begin
            $display("FAIL watchdog: %0d cycles elapsed, required completion", cycles);
            $fatal(1, "watchdog");
        end
    end

    // One frame: queue expectations, pulse sync_i, leave spacing before the next.
    task automatic frame(input logic [2:0] rdy, input logic [19:0] exp_cmd, input logic exp_mk);
        cmd_exp_t e;
        e.tdata  = exp_cmd;
        e.marked = exp_mk;
        q_rdy.push_back(rdy);
        q_cmd.push_back(e);
        @(posedge clk); #1 sync = 1'b1;
        @(posedge clk); #1 sync = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset and reset-state check.
        repeat (3) @(posedge clk);
        #1 chk_reset = 1'b1;
        @(posedge clk); #1 chk_reset = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Idle frames.
        for (int i = 0; i < 3; i++) frame(3'b000, 20'h00000, 1'b0);

        // Trig beats runcmd, then runcmd alone.
        trig_tdata = 15'h1234; trig_tvalid = 1'b1;
        runcmd_tdata = 2'd2;   runcmd_tvalid = 1'b1;
        frame(3'b010, 20'h81234, 1'b0);
        trig_tvalid = 1'b0;
        frame(3'b001, 20'h40002, 1'b0);
        runcmd_tvalid = 1'b0;

        // fw starves behind trig: four trig frames, then forced fw; again after clear.
        trig_tdata = 15'h0011; trig_tvalid = 1'b1;
        fw_tdata = 8'hA5;      fw_tvalid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) frame(3'b010, 20'h80011, 1'b0);
            frame(3'b100, 20'hC00A5, 1'b0);
        end
        fw_tvalid = 1'b0;

        // Both starving: runcmd forced first, fw one frame later.
        runcmd_tdata = 2'd1; runcmd_tvalid = 1'b1;
        fw_tdata = 8'h5A;    fw_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) frame(3'b010, 20'h80011, 1'b0);
        frame(3'b001, 20'h40001, 1'b0);
        frame(3'b100, 20'hC005A, 1'b0);
        runcmd_tvalid = 1'b0; fw_tvalid = 1'b0; trig_tvalid = 1'b0;

        // Marks.
        fw_mark = 2'b10; fw_tdata = 8'h3C; fw_tvalid = 1'b1;
        frame(3'b100, 20'hE003C, 1'b1);
        fw_tvalid = 1'b0; fw_mark = 2'b01;
        frame(3'b000, 20'h00000, 1'b0);
        fw_mark = 2'b00;

        // Build fw starvation to 2, then reset on the sync edge.
        trig_tvalid = 1'b1; fw_tdata = 8'h77; fw_tvalid = 1'b1;
        frame(3'b010, 20'h80011, 1'b0);
        frame(3'b010, 20'h80011, 1'b0);
        q_rdy.push_back(3'b000);
        @(posedge clk); #1 sync = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1 sync = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Counters cleared: fw needs the full four lost frames again.
        for (int i = 0; i < 4; i++) frame(3'b010, 20'h80011, 1'b0);
        frame(3'b100, 20'hC0077, 1'b0);
        trig_tvalid = 1'b0; fw_tvalid = 1'b0;

        repeat (3) @(posedge clk);
        #1 done = 1'b1;
    end

endmodule
